// File: rtl/iec_pkg.sv
// Shared IEC serial-bus types: initiator FSM states, result codes and default timing.
// Declarations only; no logic, latency or flow control of its own.
package iec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ATN_SETUP,
    ST_ATN_TURN,
    ST_WAIT_LSN,
    ST_READY,
    ST_WAIT_DHI,
    ST_EOI_LO,
    ST_EOI_HI,
    ST_BIT_SETUP,
    ST_BIT_VALID,
    ST_FRAME_ACK,
    ST_FINISH,
    ST_FAIL
  } iec_state_e;

  localparam logic [1:0] RES_OK    = 2'b00;
  localparam logic [1:0] RES_NODEV = 2'b01;
  localparam logic [1:0] RES_NOACK = 2'b10;

  localparam int DEF_CLK_DIV  = 32;
  localparam int DEF_T_ACK_US = 1000;
  localparam int DEF_T_BIT_US = 20;
  localparam int US_W         = 10;

endpackage

// File: rtl/iec_us_timer.sv
// Microsecond down-counter: CLK_DIV-cycle prescaler and count both restart on load.
// expired is decoded from registers; load always wins, no backpressure.
module iec_us_timer
  import iec_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic            clk32,
  input  logic            reset_n,
  input  logic            load,
  input  logic [US_W-1:0] value,
  output logic            expired
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0]   pre_q;
  logic [US_W-1:0] cnt_q;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      pre_q <= '0;
      cnt_q <= value;
    end else if (pre_q == PW'(CLK_DIV - 1)) begin
      pre_q <= '0;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/iec_host_tx.sv
// IEC serial-bus initiator: sends ATN command and data bytes with EOI and ack timeouts.
// Lines change 1 cycle after accept; one byte in flight, tx_ready returns the cycle after res_valid.
module iec_host_tx
  import iec_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int T_ACK_US = DEF_T_ACK_US,
  parameter int T_BIT_US = DEF_T_BIT_US
) (
  input  logic       clk32,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       bus_release,
  output logic       res_valid,
  output logic [1:0] res_code,
  output logic       sb_atn_out,
  output logic       sb_clk_out,
  output logic       sb_data_out,
  input  logic       sb_atn_in,
  input  logic       sb_clk_in,
  input  logic       sb_data_in
);

  iec_state_e      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            eoi_q, eoi_d;
  logic [2:0]      idx_q, idx_d;
  logic            seen_q, seen_d;
  logic [1:0]      code_q, code_d;
  logic            atn_q, atn_d, clk_q, clk_d, data_q, data_d;
  logic [2:0]      sync1_q, sync2_q, filt_q, agree;
  logic            data_f, unused_bus;
  logic            tmr_load, tmr_exp, seen_load;
  logic [US_W-1:0] tmr_val;

  // Filtered bus levels only move when both synchroniser stages agree.
  assign agree      = ~(sync1_q ^ sync2_q);
  assign data_f     = filt_q[0];
  assign unused_bus = ^filt_q[2:1];

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
    end else begin
      sync1_q <= {sb_atn_in, sb_clk_in, sb_data_in};
      sync2_q <= sync1_q;
      filt_q  <= (sync2_q & agree) | (filt_q & ~agree);
    end
  end

  iec_us_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk32   (clk32),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  // seen_q: in WAIT_DHI the settle delay is running; in FRAME_ACK DATA has been
  // observed released, so a stale low from bit 7 is not taken as the ack.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    eoi_d     = eoi_q;
    idx_d     = idx_q;
    seen_d    = seen_q;
    code_d    = code_q;
    seen_load = 1'b0;
    case (state_q)
      ST_IDLE: if (tx_valid) begin
        byte_d = tx_data;
        eoi_d  = tx_eoi & ~tx_atn;
        idx_d  = 3'd0;
        if (tx_atn)      state_d = ST_ATN_SETUP;
        else if (!atn_q) state_d = ST_ATN_TURN;
        else             state_d = ST_READY;
      end
      ST_ATN_SETUP: state_d = ST_WAIT_LSN;
      ST_ATN_TURN:  if (tmr_exp) state_d = ST_READY;
      ST_WAIT_LSN: begin
        if (!data_f) state_d = ST_READY;
        else if (tmr_exp) begin
          state_d = ST_FAIL;
          code_d  = RES_NODEV;
        end
      end
      ST_READY: begin
        seen_d  = 1'b0;
        state_d = ST_WAIT_DHI;
      end
      ST_WAIT_DHI: begin
        if (!seen_q) begin
          if (data_f) begin
            if (eoi_q) state_d = ST_EOI_LO;
            else begin
              seen_d    = 1'b1;
              seen_load = 1'b1;
            end
          end
        end else if (tmr_exp) state_d = ST_BIT_SETUP;
      end
      ST_EOI_LO: begin
        if (!data_f) state_d = ST_EOI_HI;
        else if (tmr_exp) begin
          state_d = ST_FAIL;
          code_d  = RES_NODEV;
        end
      end
      ST_EOI_HI: begin
        if (data_f) state_d = ST_BIT_SETUP;
        else if (tmr_exp) begin
          state_d = ST_FAIL;
          code_d  = RES_NODEV;
        end
      end
      ST_BIT_SETUP: if (tmr_exp) state_d = ST_BIT_VALID;
      ST_BIT_VALID: if (tmr_exp) begin
        if (idx_q == 3'd7) begin
          seen_d  = 1'b0;
          state_d = ST_FRAME_ACK;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_BIT_SETUP;
        end
      end
      ST_FRAME_ACK: begin
        if (data_f) seen_d = 1'b1;
        if (seen_q && !data_f) begin
          state_d = ST_FINISH;
          code_d  = RES_OK;
        end else if (tmr_exp) begin
          state_d = ST_FAIL;
          code_d  = RES_NOACK;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign tmr_load = (state_d != state_q) | seen_load;
  assign tmr_val  = (state_d inside {ST_WAIT_LSN, ST_EOI_LO, ST_EOI_HI, ST_FRAME_ACK})
                    ? US_W'(T_ACK_US) : US_W'(T_BIT_US);

  // Line levels are a function of the state being entered, so they register with it.
  always_comb begin
    atn_d  = atn_q;
    clk_d  = clk_q;
    data_d = data_q;
    case (state_d)
      ST_IDLE: begin
        data_d = 1'b1;
        if (state_q == ST_IDLE && bus_release) begin
          atn_d = 1'b1;
          clk_d = 1'b1;
        end
      end
      ST_ATN_SETUP, ST_WAIT_LSN: begin
        atn_d  = 1'b0;
        clk_d  = 1'b0;
        data_d = 1'b1;
      end
      ST_ATN_TURN: begin
        atn_d  = 1'b1;
        data_d = 1'b1;
      end
      ST_READY, ST_WAIT_DHI, ST_EOI_LO, ST_EOI_HI: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
      end
      ST_BIT_SETUP: begin
        clk_d  = 1'b0;
        data_d = byte_d[idx_d];
      end
      ST_BIT_VALID: begin
        clk_d  = 1'b1;
        data_d = byte_d[idx_d];
      end
      ST_FRAME_ACK, ST_FINISH: begin
        clk_d  = 1'b0;
        data_d = 1'b1;
      end
      default: begin
        atn_d  = 1'b1;
        clk_d  = 1'b1;
        data_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      eoi_q   <= 1'b0;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      code_q  <= RES_OK;
      atn_q   <= 1'b1;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      eoi_q   <= eoi_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      code_q  <= code_d;
      atn_q   <= atn_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_FINISH) || (state_q == ST_FAIL);
  assign res_code    = code_q;
  assign sb_atn_out  = atn_q;
  assign sb_clk_out  = clk_q;
  assign sb_data_out = data_q;

endmodule

// File: tb/tb_iec_host_tx.sv
// Directed bench for iec_host_tx with a wired-AND bus and a scripted listener on DATA.
// Runs the prescaler at 4 cycles per microsecond so 1000 us timeouts stay short.
module tb_iec_host_tx;

  localparam int US     = 4;
  localparam int S_ATN  = 0;
  localparam int S_CLK  = 1;
  localparam int S_DATA = 2;
  localparam int S_RES  = 3;

  logic       clk32 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_atn, tx_eoi, tx_valid, bus_release;
  logic       tx_ready, res_valid;
  logic [1:0] res_code;
  logic       sb_atn_out, sb_clk_out, sb_data_out;
  logic       sb_atn_in, sb_clk_in, sb_data_in;
  logic       lsn_data;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk32 = ~clk32;

  assign sb_atn_in  = sb_atn_out;
  assign sb_clk_in  = sb_clk_out;
  assign sb_data_in = sb_data_out & lsn_data;

  iec_host_tx #(.CLK_DIV(US)) dut (
    .clk32       (clk32),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_atn      (tx_atn),
    .tx_eoi      (tx_eoi),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bus_release (bus_release),
    .res_valid   (res_valid),
    .res_code    (res_code),
    .sb_atn_out  (sb_atn_out),
    .sb_clk_out  (sb_clk_out),
    .sb_data_out (sb_data_out),
    .sb_atn_in   (sb_atn_in),
    .sb_clk_in   (sb_clk_in),
    .sb_data_in  (sb_data_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_ATN:   return sb_atn_out;
      S_CLK:   return sb_clk_out;
      S_DATA:  return sb_data_out;
      default: return res_valid;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic wait_sig(input int sel, input logic lvl, input int max, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < max) begin
      @(negedge clk32);
      n++;
    end
    if (sig(sel) !== lvl) n = -1;
  endtask

  task automatic accept(input logic [7:0] d, input logic atn, input logic eoi);
    tx_data  = d;
    tx_atn   = atn;
    tx_eoi   = eoi;
    tx_valid = 1'b1;
    @(negedge clk32);
    tx_valid = 1'b0;
    tx_data  = ~d;
    tx_atn   = ~atn;
    tx_eoi   = ~eoi;
  endtask

  task automatic recv_byte(output logic [7:0] b, output int hmin, output int hmax, output bit ok);
    int n;
    b    = '0;
    hmin = 1 << 20;
    hmax = 0;
    ok   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_sig(S_CLK, 1'b0, 400, n);
      if (n < 0) ok = 1'b0;
      wait_sig(S_CLK, 1'b1, 400, n);
      if (n < 0) ok = 1'b0;
      b[i] = sb_data_out;
      wait_sig(S_CLK, 1'b0, 400, n);
      if (n < 0) ok = 1'b0;
      if (n < hmin) hmin = n;
      if (n > hmax) hmax = n;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, want summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] b;
    int         n, hmin, hmax, lows;
    bit         ok;

    tx_data = '0; tx_atn = 1'b0; tx_eoi = 1'b0; tx_valid = 1'b0;
    bus_release = 1'b0; lsn_data = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("rst_atn", sb_atn_out, 1);
    chk("rst_clk", sb_clk_out, 1);
    chk("rst_data", sb_data_out, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_resv", res_valid, 0);
    chk("rst_code", res_code, 2'b00);

    // ATN command 0x28, listener answers 50 us after ATN
    accept(8'h28, 1'b1, 1'b0);
    chk("t1_acc_atn", sb_atn_out, 0);
    chk("t1_acc_clk", sb_clk_out, 0);
    chk("t1_busy", tx_ready, 0);
    tick(50 * US);
    chk("t1_clk_held", sb_clk_out, 0);
    lsn_data = 1'b0;
    wait_sig(S_CLK, 1'b1, 50, n);
    chk("t1_clk_rel", n >= 0, 1);
    tick(10 * US);
    lsn_data = 1'b1;
    recv_byte(b, hmin, hmax, ok);
    chk("t1_bits_ok", ok, 1);
    chk("t1_byte", b, 8'h28);
    chk("t1_hi_win", (hmin >= 20 * US) && (hmax <= 20 * US + 2), 1);
    tick(5 * US);
    lsn_data = 1'b0;
    wait_sig(S_RES, 1'b1, 50, n);
    chk("t1_done", n >= 0, 1);
    chk("t1_code", res_code, 2'b00);
    tick(1);
    chk("t1_atn_hold", sb_atn_out, 0);
    chk("t1_clk_hold", sb_clk_out, 0);
    chk("t1_ready", tx_ready, 1);

    // Data byte after command: ATN turnaround, then byte, then bus_release
    accept(8'hA3, 1'b0, 1'b0);
    chk("t5_atn_up", sb_atn_out, 1);
    chk("t5_clk_low", sb_clk_out, 0);
    tick(19 * US);
    chk("t5_turn_clk", sb_clk_out, 0);
    wait_sig(S_CLK, 1'b1, 4 * US, n);
    chk("t5_turn_end", n >= 0, 1);
    tick(10 * US);
    lsn_data = 1'b1;
    recv_byte(b, hmin, hmax, ok);
    chk("t5_bits_ok", ok, 1);
    chk("t5_byte", b, 8'hA3);
    tick(5 * US);
    lsn_data = 1'b0;
    wait_sig(S_RES, 1'b1, 50, n);
    chk("t5_done", n >= 0, 1);
    chk("t5_code", res_code, 2'b00);
    tick(1);
    chk("t5_clk_hold", sb_clk_out, 0);
    bus_release = 1'b1;
    tick(1);
    bus_release = 1'b0;
    chk("rel_atn", sb_atn_out, 1);
    chk("rel_clk", sb_clk_out, 1);
    lsn_data = 1'b1;
    tick(2);

    // ATN command with nobody on the bus
    accept(8'h3F, 1'b1, 1'b0);
    wait_sig(S_RES, 1'b1, 1100 * US, n);
    chk("t2_nodev_time", (n >= 1000 * US - 5) && (n <= 1000 * US + 5), 1);
    chk("t2_code", res_code, 2'b01);
    tick(1);
    chk("t2_atn", sb_atn_out, 1);
    chk("t2_clk", sb_clk_out, 1);
    chk("t2_data", sb_data_out, 1);
    chk("t2_ready", tx_ready, 1);

    // Last data byte 0x55 with EOI; listener acks EOI with 60 us of DATA low
    accept(8'h55, 1'b0, 1'b1);
    tick(20 * US);
    chk("t3_clk_pre", sb_clk_out, 1);
    lows = 0;
    lsn_data = 1'b0;
    for (int i = 0; i < 60 * US; i++) begin
      @(negedge clk32);
      if (!sb_clk_out) lows++;
    end
    lsn_data = 1'b1;
    chk("t3_eoi_clk_hi", lows, 0);
    recv_byte(b, hmin, hmax, ok);
    chk("t3_bits_ok", ok, 1);
    chk("t3_byte", b, 8'h55);
    tick(5 * US);
    lsn_data = 1'b0;
    wait_sig(S_RES, 1'b1, 50, n);
    chk("t3_done", n >= 0, 1);
    chk("t3_code", res_code, 2'b00);
    tick(1);

    // Listener never acknowledges the frame
    accept(8'h81, 1'b0, 1'b0);
    tick(10 * US);
    lsn_data = 1'b1;
    recv_byte(b, hmin, hmax, ok);
    chk("t4_bits_ok", ok, 1);
    chk("t4_byte", b, 8'h81);
    wait_sig(S_RES, 1'b1, 1100 * US, n);
    chk("t4_noack_time", (n >= 1000 * US - 5) && (n <= 1000 * US + 5), 1);
    chk("t4_code", res_code, 2'b10);
    tick(1);
    chk("t4_atn", sb_atn_out, 1);
    chk("t4_clk", sb_clk_out, 1);
    chk("t4_data", sb_data_out, 1);

    // Reset asserted during bit 3 setup of 0xF0 (bit 3 drives DATA low)
    accept(8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_sig(S_CLK, 1'b0, 400, n);
      wait_sig(S_CLK, 1'b1, 400, n);
    end
    wait_sig(S_CLK, 1'b0, 400, n);
    chk("t6_bit3_setup", (n >= 0) && (sb_data_out == 1'b0), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_atn", sb_atn_out, 1);
    chk("t6_clk", sb_clk_out, 1);
    chk("t6_data", sb_data_out, 1);
    chk("t6_ready", tx_ready, 1);
    chk("t6_resv", res_valid, 0);
    chk("t6_code", res_code, 2'b00);
    @(negedge clk32);
    reset_n = 1'b1;
    tick(2);
    chk("t6_ready_after", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
